// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: one iterative double-dabble binary-to-BCD engine
// shared by two requesters with round-robin arbitration and req/done handshake.
module bcd_convert_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [WIDTH-1:0]      bin0,
  input  logic                  req1,
  input  logic [WIDTH-1:0]      bin1,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done0,
  output logic                  done1,
  output logic                  busy,
  output logic                  owner
);

  // state | meaning
  // IDLE  | waiting for a request; arbitrates and loads the engine
  // SHIFT | one add-3/shift step per cycle, WIDTH cycles
  // DONE  | result registered, done pulse visible; returns to IDLE
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               busy_q, busy_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic               grant;

  // add-3 correction on every nibble (tested on pre-add values), then shift in the next binary bit
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] > 4'd4) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = (acc_adj << 1) | ACC_W'(sr_q[WIDTH-1]);
  end

  // next-state and next-output computation for the arbiter/engine FSM
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    bcd_d        = bcd_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // on a tie the side that was not granted last time wins
          grant        = (req0 && req1) ? ~last_grant_q : req1;
          sr_d         = grant ? bin1 : bin0;
          acc_d        = '0;
          cnt_d        = CNT_W'(WIDTH);
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // final shift result goes straight to the output register on DONE entry
          bcd_d   = acc_shift;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers with synchronous reset; reset discards any partial conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      bcd_q        <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      bcd_q        <= bcd_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bcd_out = bcd_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed self-checking bench for bcd_convert_arbiter (WIDTH=8, DIGITS=3).
module tb_bcd_convert_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  bin0, bin1;
  logic [11:0] bcd_out;
  logic        done0, done1, busy, owner;

  int checks = 0;
  int errors = 0;

  bcd_convert_arbiter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .bin0(bin0),
    .req1(req1), .bin1(bin1),
    .bcd_out(bcd_out), .done0(done0), .done1(done1),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] golden(input int v);
    golden = 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  // waits (bounded) for a done pulse; n = negedges elapsed, sampled away from the active edge
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done0 || done1) && n < 40);
    check("done_seen", 32'(done0 || done1), 32'd1);
    check("done_exclusive", 32'(done0 & done1), 32'd0);
  endtask

  int n, cnt;
  logic [11:0] held;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    repeat (2) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: max value on requester 0, busy throughout, latency 9
    req0 = 1'b1; bin0 = 8'hFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("t1_busy", 32'(busy), 32'd1);
    end while (!done0 && !done1 && n < 40);
    check("t1_latency", 32'(n), 32'd9);
    check("t1_done0", 32'(done0), 32'd1);
    check("t1_done1", 32'(done1), 32'd0);
    check("t1_bcd", 32'(bcd_out), 32'h255);
    check("t1_owner", 32'(owner), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    check("t1_done_pulse", 32'(done0), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);

    // 2: zero on requester 1
    req1 = 1'b1; bin1 = 8'd0;
    wait_done(n);
    check("t2_latency", 32'(n), 32'd9);
    check("t2_done1", 32'(done1), 32'd1);
    check("t2_done0", 32'(done0), 32'd0);
    check("t2_bcd", 32'(bcd_out), 32'h000);
    check("t2_owner", 32'(owner), 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    check("t2_done_pulse", 32'(done1), 32'd0);

    // 3: simultaneous requests after reset -> req0 first, req1 ten cycles later
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; bin0 = 8'd123; req1 = 1'b1; bin1 = 8'd99;
    wait_done(n);
    check("t3_first_done0", 32'(done0), 32'd1);
    check("t3_first_bcd", 32'(bcd_out), 32'h123);
    req0 = 1'b0;
    wait_done(n);
    check("t3_gap", 32'(n), 32'd10);
    check("t3_second_done1", 32'(done1), 32'd1);
    check("t3_second_bcd", 32'(bcd_out), 32'h099);
    req1 = 1'b0;
    held = bcd_out;
    repeat (5) @(negedge clk);
    check("t3_bcd_hold", 32'(bcd_out), 32'(held));
    check("t3_idle_busy", 32'(busy), 32'd0);

    // 4: both held for six conversions -> strict alternation (req1 was granted last)
    req0 = 1'b1; bin0 = 8'd17; req1 = 1'b1; bin1 = 8'd42;
    for (int i = 0; i < 6; i++) begin
      wait_done(n);
      check("t4_latency", 32'(n), (i == 0) ? 32'd9 : 32'd10);
      check("t4_owner", 32'(owner), 32'(i % 2));
      check("t4_done0", 32'(done0), 32'(i % 2 == 0));
      check("t4_bcd", 32'(bcd_out), (i % 2 == 0) ? 32'h017 : 32'h042);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // 5: reset during SHIFT cycle 4 discards the conversion
    req0 = 1'b1; bin0 = 8'd200;
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_bcd", 32'(bcd_out), 32'h0);
    check("t5_done0", 32'(done0), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 || done1) cnt++;
    end
    check("t5_no_done", 32'(cnt), 32'd0);
    req0 = 1'b1;
    wait_done(n);
    check("t5_retry_bcd", 32'(bcd_out), 32'h200);
    check("t5_retry_done0", 32'(done0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);

    // 6: sweep, alternating requesters, bin corrupted and req dropped after the grant
    for (int v = 0; v < 256; v++) begin
      if (v % 2 == 0) begin req0 = 1'b1; bin0 = 8'(v); end
      else            begin req1 = 1'b1; bin1 = 8'(v); end
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      bin0 = ~8'(v); bin1 = ~8'(v);
      wait_done(n);
      check("t6_latency", 32'(n), 32'd8);
      check("t6_bcd", 32'(bcd_out), 32'(golden(v)));
      check("t6_owner", 32'(owner), 32'(v % 2));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
